// File: rtl/demux_slot_router_pkg.sv
// Shared definitions for the output-side demultiplexer: slot state encoding,
// default geometry and the delivered-beat counter width.
// Optional feature macro used by the top level: DEMUX_CNT_EN.
package demux_slot_router_pkg;

    // One-entry holding slot occupancy
    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam int unsigned DEF_N_OUT      = 4;
    localparam int unsigned DEF_SEL_WIDTH  = 2;
    localparam int unsigned CNT_WIDTH      = 16;

    // Minimum select width able to address n ports (at least 1 bit)
    function automatic int unsigned sel_width_for(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage : demux_slot_router_pkg

// File: rtl/demux_slot.sv
// demux_slot: one-entry holding slot for a single output port.
// Ports:
//   CLK, RST_N  clock / asynchronous active-low reset
//   LOAD        write D into the slot this cycle (caller guarantees slot is
//               empty or draining in the same cycle)
//   D           incoming beat
//   Q, Q_VALID  held beat and occupancy flag
//   Q_READY     consumer ready; drains the slot when Q_VALID is set
module demux_slot
    import demux_slot_router_pkg::*;
#(
    parameter int unsigned Data_Width = DEF_DATA_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  LOAD,
    input  logic [Data_Width-1:0] D,
    output logic [Data_Width-1:0] Q,
    output logic                  Q_VALID,
    input  logic                  Q_READY
);

    slot_state_e state_q;
    slot_state_e state_d;

    // State register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= SLOT_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a load while full (drain + refill) keeps the slot full
    always_comb begin
        state_d = state_q;
        case (state_q)
            SLOT_EMPTY: begin
                if (LOAD) begin
                    state_d = SLOT_FULL;
                end
            end
            SLOT_FULL: begin
                if (!LOAD && Q_READY) begin
                    state_d = SLOT_EMPTY;
                end
            end
        endcase
    end

    // Output decode
    always_comb begin
        Q_VALID = 1'b0;
        if (state_q == SLOT_FULL) begin
            Q_VALID = 1'b1;
        end
    end

    // Data register; only written on load so Q is stable while stalled
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            Q <= '0;
        end else if (LOAD) begin
            Q <= D;
        end
    end

endmodule : demux_slot

// File: rtl/demux_slot_router.sv
// demux_slot_router: routes one valid/ready input stream to one of N_Out
// output ports chosen per beat by S. Each port owns a one-entry slot, so a
// stalled port never blocks beats bound for the other ports.
// Ports:
//   CLK, RST_N        clock / asynchronous active-low reset
//   X, X_VALID, S     input beat, valid and destination port
//   X_READY           input accepted when X_VALID & X_READY (combinational)
//   Y, Y_VALID        port k data at Y[k*Data_Width +: Data_Width], occupancy
//   Y_READY           per-port consumer ready
//   SEL_ERR           one-cycle pulse after a beat with S >= N_Out was dropped
//   CNT               (only with DEMUX_CNT_EN) per-port 16-bit delivered count
module demux_slot_router
    import demux_slot_router_pkg::*;
#(
    parameter int unsigned Data_Width = DEF_DATA_WIDTH,
    parameter int unsigned N_Out      = DEF_N_OUT,
    parameter int unsigned Sel_Width  = DEF_SEL_WIDTH
) (
    input  logic                        CLK,
    input  logic                        RST_N,
    input  logic [Data_Width-1:0]       X,
    input  logic                        X_VALID,
    input  logic [Sel_Width-1:0]        S,
    output logic                        X_READY,
    output logic [N_Out*Data_Width-1:0] Y,
    output logic [N_Out-1:0]            Y_VALID,
    input  logic [N_Out-1:0]            Y_READY,
    output logic                        SEL_ERR
`ifdef DEMUX_CNT_EN
    ,
    output logic [N_Out*CNT_WIDTH-1:0]  CNT
`endif
);

    localparam int unsigned CMP_W = Sel_Width + 1;

    // Configuration sanity
    if (N_Out < 2 || N_Out > 16 || Sel_Width < sel_width_for(N_Out)) begin : g_bad_cfg
        $error("demux_slot_router: unsupported N_Out/Sel_Width combination");
    end

    logic             sel_oor_c;
    logic             port_ready_c;
    logic             accept_c;
    logic [N_Out-1:0] load_c;

    // Extra bit keeps the compare correct when 2**Sel_Width == N_Out
    assign sel_oor_c = (CMP_W'(S) >= CMP_W'(N_Out));

    // Selected port can take a beat if its slot is empty or draining now
    always_comb begin
        port_ready_c = 1'b1;
        for (int unsigned k = 0; k < N_Out; k++) begin
            if (S == Sel_Width'(k)) begin
                port_ready_c = ~Y_VALID[k] | Y_READY[k];
            end
        end
    end

    assign X_READY  = RST_N & port_ready_c;
    assign accept_c = X_VALID & X_READY;

    // Select decode into per-slot load strobes
    always_comb begin
        load_c = '0;
        for (int unsigned k = 0; k < N_Out; k++) begin
            if (S == Sel_Width'(k)) begin
                load_c[k] = accept_c;
            end
        end
    end

    // Dropped-beat indication
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            SEL_ERR <= 1'b0;
        end else begin
            SEL_ERR <= accept_c & sel_oor_c;
        end
    end

    // Per-port holding slots (and optional delivered-beat counters)
    for (genvar k = 0; k < N_Out; k++) begin : g_port
        demux_slot #(
            .Data_Width (Data_Width)
        ) u_slot (
            .CLK     (CLK),
            .RST_N   (RST_N),
            .LOAD    (load_c[k]),
            .D       (X),
            .Q       (Y[k*Data_Width +: Data_Width]),
            .Q_VALID (Y_VALID[k]),
            .Q_READY (Y_READY[k])
        );

`ifdef DEMUX_CNT_EN
        logic [CNT_WIDTH-1:0] cnt_q;

        // Free-running wrap at 16'hFFFF -> 0
        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                cnt_q <= '0;
            end else if (Y_VALID[k] & Y_READY[k]) begin
                cnt_q <= cnt_q + CNT_WIDTH'(1);
            end
        end

        assign CNT[k*CNT_WIDTH +: CNT_WIDTH] = cnt_q;
`endif
    end

    // S must be known whenever it is qualified
    sel_known_a : assert property (@(posedge CLK) disable iff (!RST_N)
                                   X_VALID |-> !$isunknown(S))
        else $error("demux_slot_router: S unknown while X_VALID is high");

endmodule : demux_slot_router

// File: tb/tb_demux_slot_router.sv
// Scoreboard bench for demux_slot_router: 4 ports, 3-bit select so that
// S = 4..7 exercises the out-of-range path.
module tb_demux_slot_router;

    localparam int unsigned DW = 8;
    localparam int unsigned NO = 4;
    localparam int unsigned SW = 3;

    logic             CLK;
    logic             RST_N;
    logic [DW-1:0]    X;
    logic             X_VALID;
    logic [SW-1:0]    S;
    logic             X_READY;
    logic [NO*DW-1:0] Y;
    logic [NO-1:0]    Y_VALID;
    logic [NO-1:0]    Y_READY;
    logic             SEL_ERR;
`ifdef DEMUX_CNT_EN
    logic [NO*16-1:0] CNT;
    logic [15:0]      cnt_m [NO];
`endif

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] exp_q [NO][$];
    logic       exp_sel_err;
    logic       occ [NO];

    demux_slot_router #(
        .Data_Width (DW),
        .N_Out      (NO),
        .Sel_Width  (SW)
    ) dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .X       (X),
        .X_VALID (X_VALID),
        .S       (S),
        .X_READY (X_READY),
        .Y       (Y),
        .Y_VALID (Y_VALID),
        .Y_READY (Y_READY),
        .SEL_ERR (SEL_ERR)
`ifdef DEMUX_CNT_EN
        ,
        .CNT     (CNT)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: compare current outputs, then account for this edge's transfers
    always @(negedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int k = 0; k < NO; k++) begin
                exp_q[k].delete();
`ifdef DEMUX_CNT_EN
                cnt_m[k] = 16'd0;
`endif
            end
            exp_sel_err = 1'b0;
        end else begin
            logic oor;
            logic exp_rdy;
            int   si;
            check("sel_err", 64'(SEL_ERR), 64'(exp_sel_err));
            for (int k = 0; k < NO; k++) begin
                occ[k] = (exp_q[k].size() != 0);
                check("y_valid", 64'(Y_VALID[k]), 64'(occ[k]));
                if (occ[k]) begin
                    check("y_data", 64'(Y[k*DW +: DW]), 64'(exp_q[k][0]));
                end
`ifdef DEMUX_CNT_EN
                check("cnt", 64'(CNT[k*16 +: 16]), 64'(cnt_m[k]));
`endif
            end
            for (int k = 0; k < NO; k++) begin
                if (occ[k] && Y_READY[k]) begin
                    void'(exp_q[k].pop_front());
`ifdef DEMUX_CNT_EN
                    cnt_m[k] = cnt_m[k] + 16'd1;
`endif
                end
            end
            exp_sel_err = 1'b0;
            oor     = (S >= 3'd4);
            si      = int'(S[1:0]);
            exp_rdy = oor || !occ[si] || Y_READY[si];
            check("x_ready", 64'(X_READY), 64'(exp_rdy));
            if (X_VALID && exp_rdy) begin
                if (oor) exp_sel_err = 1'b1;
                else     exp_q[si].push_back(X);
            end
        end
    end

    // Present a beat and hold it until accepted; starts and ends just after a posedge
    task automatic send(input logic [7:0] d, input logic [2:0] s, output int waited);
        X = d;
        S = s;
        X_VALID = 1'b1;
        waited = 0;
        forever begin
            @(negedge CLK);
            if (X_READY) break;
            waited++;
            if (waited > 50) begin
                check("send_timeout", 64'(waited), 64'(0));
                break;
            end
        end
        @(posedge CLK);
        #1;
        X_VALID = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    initial begin
        int w;
        // Reset with a valid beat presented
        RST_N = 1'b0;
        X = 8'h55;
        S = 3'd0;
        X_VALID = 1'b1;
        Y_READY = 4'b0000;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_x_ready", 64'(X_READY), 64'(0));
        check("rst_y_valid", 64'(Y_VALID), 64'(0));
        check("rst_y", 64'(Y), 64'(0));
        check("rst_sel_err", 64'(SEL_ERR), 64'(0));
        X_VALID = 1'b0;
        RST_N = 1'b1;
        idle(2);
        check("post_rst_y_valid", 64'(Y_VALID), 64'(0));
        check("post_rst_sel_err", 64'(SEL_ERR), 64'(0));

        // Routing, back-to-back
        Y_READY = 4'b1111;
        send(8'h11, 3'd0, w);
        check("route0_wait", 64'(w), 64'(0));
        check("route0_valid", 64'(Y_VALID[0]), 64'(1));
        check("route0_data", 64'(Y[7:0]), 64'(8'h11));
        send(8'h22, 3'd2, w);
        check("route2_wait", 64'(w), 64'(0));
        check("route2_valid", 64'(Y_VALID[2]), 64'(1));
        check("route2_data", 64'(Y[23:16]), 64'(8'h22));
        for (int i = 0; i < 8; i++) begin
            send(8'(8'h30 + i), 3'(i % 4), w);
            check("stream_wait", 64'(w), 64'(0));
        end
        idle(2);

        // Backpressure on port 1; port 3 unaffected
        Y_READY = 4'b1101;
        send(8'hA1, 3'd1, w);
        X = 8'hA2;
        S = 3'd1;
        X_VALID = 1'b1;
        @(negedge CLK);
        check("bp_blocked", 64'(X_READY), 64'(0));
        idle(1);
        send(8'hB3, 3'd3, w);
        check("bp_other_port", 64'(w), 64'(0));
        check("bp_hold_data", 64'(Y[15:8]), 64'(8'hA1));
        X = 8'hA2;
        S = 3'd1;
        X_VALID = 1'b1;
        Y_READY = 4'b1111;
        @(negedge CLK);
        check("bp_drain_refill", 64'(X_READY), 64'(1));
        @(posedge CLK);
        #1;
        X_VALID = 1'b0;
        check("bp_refill_valid", 64'(Y_VALID[1]), 64'(1));
        check("bp_refill_data", 64'(Y[15:8]), 64'(8'hA2));
        idle(2);

        // Out-of-range select, including while the addressed-looking port is full
        Y_READY = 4'b0000;
        send(8'h5D, 3'd1, w);
        send(8'hFF, 3'd4, w);
        check("oor4_wait", 64'(w), 64'(0));
        check("oor4_sel_err", 64'(SEL_ERR), 64'(1));
        check("oor4_y_valid", 64'(Y_VALID), 64'(4'b0010));
        idle(1);
        check("oor_pulse_end", 64'(SEL_ERR), 64'(0));
        send(8'hFF, 3'd5, w);
        check("oor5_wait", 64'(w), 64'(0));
        send(8'hEE, 3'd7, w);
        check("oor7_sel_err", 64'(SEL_ERR), 64'(1));
        Y_READY = 4'b1111;
        idle(3);

        // Reset pulse between edges with slots 0 and 2 full
        Y_READY = 4'b0000;
        send(8'h5A, 3'd0, w);
        send(8'hC5, 3'd2, w);
        check("mid_full", 64'(Y_VALID), 64'(4'b0101));
        #1;
        RST_N = 1'b0;
        X = 8'h77;
        S = 3'd0;
        X_VALID = 1'b1;
        #1;
        check("mid_rst_y_valid", 64'(Y_VALID), 64'(0));
        check("mid_rst_x_ready", 64'(X_READY), 64'(0));
        check("mid_rst_y", 64'(Y), 64'(0));
        #1;
        X_VALID = 1'b0;
        RST_N = 1'b1;
        Y_READY = 4'b1111;
        idle(4);
        check("mid_post_empty", 64'(Y_VALID), 64'(0));

`ifdef DEMUX_CNT_EN
        // Delivered-beat counter and wrap on port 2
        for (int i = 0; i < 3; i++) send(8'(i), 3'd2, w);
        idle(2);
        check("cnt_three", 64'(CNT[47:32]), 64'(3));
        for (int i = 0; i < 65532; i++) send(8'(i), 3'd2, w);
        idle(2);
        check("cnt_max", 64'(CNT[47:32]), 64'(16'hFFFF));
        send(8'h99, 3'd2, w);
        idle(2);
        check("cnt_wrap", 64'(CNT[47:32]), 64'(0));
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_demux_slot_router
